// File: rtl/bch_encoder.sv
// Systematic BCH(63,39) t=4 encoder: bit-serial LFSR division by g(x), MSB first.
// Optional BCH_ENC_ERR_INJECT_EN adds inject_mask, XORed into the finished codeword.
module bch_encoder #(
    parameter int              K        = 39,
    parameter int              PAR      = 24,
    parameter logic [PAR-1:0]  GEN_POLY = 24'hDB2777
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [K-1:0]     data,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [K+PAR:0]   inject_mask,
`endif
    output logic             busy,
    output logic             finishFlag,
    output logic [K+PAR:0]   codeword
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [5:0] CNT_LAST = 6'(K - 1);

    state_t         state;
    logic           start_d;
    logic [K-1:0]   data_sh;
    logic [PAR-1:0] r;
    logic [5:0]     cnt;
    logic           fb;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [K+PAR:0] mask;
`endif

    assign fb = data_sh[cnt] ^ r[PAR-1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            data_sh    <= '0;
            r          <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            finishFlag <= 1'b0;
            codeword   <= '0;
`ifdef BCH_ENC_ERR_INJECT_EN
            mask       <= '0;
`endif
        end else begin
            // start_d tracks start in every state so an edge seen while busy is consumed
            start_d    <= start;
            finishFlag <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        data_sh <= data;
                        r       <= '0;
                        cnt     <= CNT_LAST;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef BCH_ENC_ERR_INJECT_EN
                        mask    <= inject_mask;
`endif
                    end
                end
                SHIFT: begin
                    r <= {r[PAR-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - 6'd1;
                end
                DONE: begin
`ifdef BCH_ENC_ERR_INJECT_EN
                    codeword <= {1'b0, data_sh, r} ^ mask;
`else
                    codeword <= {1'b0, data_sh, r};
`endif
                    finishFlag <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_encoder.sv
// Directed bench for bch_encoder: reset, known codewords, latency, divisibility by g(x),
// linearity, ignored start edges and mid-encode reset.
module tb_bch_encoder;

    localparam logic [24:0] G_FULL = 25'h1DB2777;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [38:0] data = '0;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [63:0] inject_mask = '0;
`endif
    logic        busy;
    logic        finishFlag;
    logic [63:0] codeword;

    int checks = 0;
    int errors = 0;

    bch_encoder dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .data       (data),
`ifdef BCH_ENC_ERR_INJECT_EN
        .inject_mask(inject_mask),
`endif
        .busy       (busy),
        .finishFlag (finishFlag),
        .codeword   (codeword)
    );

    always #5 clk = ~clk;

    // Remainder of a 63-bit polynomial modulo g(x) by long division.
    function automatic logic [23:0] poly_mod(input logic [62:0] c);
        logic [62:0] v;
        v = c;
        for (int i = 62; i >= 24; i--)
            if (v[i]) v[i -: 25] = v[i -: 25] ^ G_FULL;
        return v[23:0];
    endfunction

    function automatic logic [63:0] model_cw(input logic [38:0] d);
        logic [62:0] shifted;
        shifted = {d, 24'h0};
        return {1'b0, d, poly_mod(shifted)};
    endfunction

    function automatic logic [38:0] rand39();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[38:0];
    endfunction

    // Start one encode; lat = edges from accepting edge to finishFlag, -1 on timeout.
    task automatic encode(input logic [38:0] d, output logic [63:0] cw, output int lat);
        lat = -1;
        cw  = '0;
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        data  = ~d;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (finishFlag) begin
                lat = n;
                cw  = codeword;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (codeword !== 64'h0 || finishFlag !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles, last cw=%h ff=%b busy=%b required all 0",
                     bad, codeword, finishFlag, busy);
        end
    endtask

    task automatic test_known;
        logic [38:0] din [3];
        logic [63:0] exp [3];
        logic [63:0] cw;
        int lat;
        din[0] = 39'h0; exp[0] = 64'h0;
        din[1] = 39'h1; exp[1] = 64'h0000_0000_01DB_2777;
        din[2] = 39'h3; exp[2] = 64'h0000_0000_03B6_4EEE;
        for (int i = 0; i < 3; i++) begin
            encode(din[i], cw, lat);
            checks++;
            if (lat != 40) begin
                errors++;
                $display("FAIL known_latency[%0d]: got %0d required 40", i, lat);
            end
            checks++;
            if (cw !== exp[i]) begin
                errors++;
                $display("FAIL known_cw[%0d]: got %h required %h", i, cw, exp[i]);
            end
        end
    endtask

    task automatic test_pulse_shape;
        logic [63:0] cw;
        int lat;
        encode(39'h7F_FFFF_FFFF, cw, lat);
        checks++;
        if (lat != 40 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_busy: lat=%0d busy=%b required 40, 0", lat, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (finishFlag !== 1'b0 || codeword !== model_cw(39'h7F_FFFF_FFFF)) begin
            errors++;
            $display("FAIL pulse_hold: ff=%b cw=%h required 0, %h",
                     finishFlag, codeword, model_cw(39'h7F_FFFF_FFFF));
        end
    endtask

    task automatic test_random;
        logic [38:0] d;
        logic [63:0] cw;
        int lat, bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            d = rand39();
            encode(d, cw, lat);
            if (lat != 40 || cw !== model_cw(d) || poly_mod(cw[62:0]) !== 24'h0) begin
                bad++;
                if (bad <= 3)
                    $display("FAIL random[%0d]: d=%h cw=%h lat=%0d required cw=%h lat=40",
                             i, d, cw, lat, model_cw(d));
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_linearity;
        logic [38:0] a, b;
        logic [63:0] ca, cb, cab;
        int la, lb, lab;
        for (int i = 0; i < 4; i++) begin
            a = rand39();
            b = rand39();
            encode(a, ca, la);
            encode(b, cb, lb);
            encode(a ^ b, cab, lab);
            checks++;
            if (cab !== (ca ^ cb) || lab != 40) begin
                errors++;
                $display("FAIL linearity[%0d]: enc(a^b)=%h required %h", i, cab, ca ^ cb);
            end
        end
    endtask

    task automatic test_back_to_back;
        int flags, first;
        flags = 0;
        first = -1;
        @(negedge clk);
        data  = 39'h2A_5A5A_5A5A;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n == 10) start = 1'b1;
            @(posedge clk);
            #1;
            if (finishFlag) begin
                flags++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        checks++;
        if (flags != 1 || first != 40) begin
            errors++;
            $display("FAIL ignore_start: pulses=%0d first=%0d required 1 at 40", flags, first);
        end
        checks++;
        if (codeword !== model_cw(39'h2A_5A5A_5A5A)) begin
            errors++;
            $display("FAIL ignore_start_cw: got %h required %h", codeword, model_cw(39'h2A_5A5A_5A5A));
        end
    endtask

    task automatic test_abort;
        int flags;
        flags = 0;
        @(negedge clk);
        data  = 39'h15_1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(posedge clk);
            #1;
        end
        resetN = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || finishFlag !== 1'b0 || codeword !== 64'h0) begin
            errors++;
            $display("FAIL abort_now: busy=%b ff=%b cw=%h required 0", busy, finishFlag, codeword);
        end
        @(negedge clk);
        resetN = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (finishFlag || busy) flags++;
        end
        checks++;
        if (flags != 0 || codeword !== 64'h0) begin
            errors++;
            $display("FAIL abort_after: %0d active cycles cw=%h required 0", flags, codeword);
        end
    endtask

`ifdef BCH_ENC_ERR_INJECT_EN
    task automatic test_inject;
        logic [63:0] cw;
        int lat;
        inject_mask = 64'h1;
        encode(39'h1, cw, lat);
        inject_mask = 64'h0;
        checks++;
        if (cw !== 64'h0000_0000_01DB_2776 || poly_mod(cw[62:0]) === 24'h0) begin
            errors++;
            $display("FAIL inject: got %h required 00000000_01db2776 with nonzero remainder", cw);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_pulse_shape();
        test_random();
        test_linearity();
        test_back_to_back();
        test_abort();
`ifdef BCH_ENC_ERR_INJECT_EN
        test_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
